// File: rtl/waypoint_sequencer.sv
// Waypoint record/playback controller.
// Captures live X/Y duty on button presses (RECORD), steps through stored waypoints at a
// fixed rate (PLAY), sequences a full memory clear (CLEAR) and muxes live or played-back
// duty onto the PWM inputs. All outputs are registered.
// Optional build macro ONESHOT_PLAY_EN: playback stops on the last waypoint and a
// Play_Done output is added.
module waypoint_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 6,
  parameter int unsigned STEP_CYCLES = 4096
) (
  input  logic              sysclk,
  input  logic              Reset_Sw,
  input  logic              Clear_Sw,
  input  logic              Record_Sw,
  input  logic              Play_Sw,
  input  logic              Bt_Up,
  input  logic              Bt_Down,
  input  logic              Bt_Left,
  input  logic              Bt_Right,
  input  logic [DATA_W-1:0] Duty_X,
  input  logic [DATA_W-1:0] Duty_Y,
  input  logic [DATA_W-1:0] Mem_Rd_X,
  input  logic [DATA_W-1:0] Mem_Rd_Y,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Waddr,
  output logic [DATA_W-1:0] Mem_Wd_X,
  output logic [DATA_W-1:0] Mem_Wd_Y,
  output logic [ADDR_W-1:0] Mem_Raddr,
  output logic [DATA_W-1:0] DC_X,
  output logic [DATA_W-1:0] DC_Y,
  output logic [ADDR_W:0]   Wp_Count,
  output logic              Full,
`ifdef ONESHOT_PLAY_EN
  output logic              Play_Done,
`endif
  output logic              Busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StClear  = 2'd1;
  localparam logic [1:0] StRecord = 2'd2;
  localparam logic [1:0] StPlay   = 2'd3;

  localparam int unsigned TimerW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(STEP_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
  localparam logic [ADDR_W-1:0] AddrMax   = '1;
  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   DepthCnt  = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d, mode;
  logic              any_bt, any_bt_q, press;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_W-1:0] wdx_q, wdx_d, wdy_q, wdy_d;
  logic [DATA_W-1:0] dcx_q, dcx_d, dcy_q, dcy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, cnt_last;
  logic              full_q, full_d, busy_q, busy_d;
`ifdef ONESHOT_PLAY_EN
  logic              done_q, done_d;
  logic [ADDR_W:0]   cnt_d_last;
`endif

  // Next-state, write strobe, playback address and duty mux
  always_comb begin
    any_bt   = Bt_Up | Bt_Down | Bt_Left | Bt_Right;
    press    = any_bt & ~any_bt_q;
    cnt_last = cnt_q - CntOne;
    if (Clear_Sw)       mode = StClear;
    else if (Record_Sw) mode = StRecord;
    else if (Play_Sw)   mode = StPlay;
    else                mode = StIdle;

    state_d = state_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdx_d   = wdx_q;
    wdy_d   = wdy_q;
    raddr_d = raddr_q;
    dcx_d   = dcx_q;
    dcy_d   = dcy_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;

    case (state_q)
      StClear: begin
        busy_d = 1'b1;
        we_d   = 1'b1;
        wdx_d  = '0;
        wdy_d  = '0;
        if (waddr_q == AddrMax) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          waddr_d = waddr_q + AddrOne;
        end
      end
      StRecord: begin
        dcx_d = Duty_X;
        dcy_d = Duty_Y;
        if (press && !full_q) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdx_d   = Duty_X;
          wdy_d   = Duty_Y;
          cnt_d   = cnt_q + CntOne;
        end
      end
      StPlay: begin
        if (cnt_q == '0) begin
          dcx_d = Duty_X;
          dcy_d = Duty_Y;
        end else begin
          dcx_d = Mem_Rd_X;
          dcy_d = Mem_Rd_Y;
        end
        if (timer_q == TimerLast) begin
          timer_d = '0;
          if (cnt_q == '0) begin
            raddr_d = '0;
          end else if ({1'b0, raddr_q} == cnt_last) begin
`ifdef ONESHOT_PLAY_EN
            raddr_d = raddr_q;
`else
            raddr_d = '0;
`endif
          end else begin
            raddr_d = raddr_q + AddrOne;
          end
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      default: begin
        dcx_d = Duty_X;
        dcy_d = Duty_Y;
      end
    endcase

    // Mode switches are honoured everywhere except inside a running clear
    if (state_q != StClear) begin
      state_d = mode;
      if (mode == StClear) begin
        we_d    = 1'b1;
        waddr_d = '0;
        wdx_d   = '0;
        wdy_d   = '0;
        busy_d  = 1'b1;
      end else if (mode == StPlay && state_q != StPlay) begin
        raddr_d = '0;
        timer_d = '0;
      end
    end

    full_d = (cnt_d == DepthCnt);
`ifdef ONESHOT_PLAY_EN
    cnt_d_last = cnt_d - CntOne;
    done_d = (state_d == StPlay) && ((cnt_d == '0) || ({1'b0, raddr_d} == cnt_d_last));
`endif
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge sysclk) begin
    if (Reset_Sw) begin
      state_q  <= StIdle;
      any_bt_q <= 1'b0;
      timer_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdx_q    <= '0;
      wdy_q    <= '0;
      raddr_q  <= '0;
      dcx_q    <= '0;
      dcy_q    <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ONESHOT_PLAY_EN
      done_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      any_bt_q <= any_bt;
      timer_q  <= timer_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdx_q    <= wdx_d;
      wdy_q    <= wdy_d;
      raddr_q  <= raddr_d;
      dcx_q    <= dcx_d;
      dcy_q    <= dcy_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
`ifdef ONESHOT_PLAY_EN
      done_q   <= done_d;
`endif
    end
  end

  assign Mem_We    = we_q;
  assign Mem_Waddr = waddr_q;
  assign Mem_Wd_X  = wdx_q;
  assign Mem_Wd_Y  = wdy_q;
  assign Mem_Raddr = raddr_q;
  assign DC_X      = dcx_q;
  assign DC_Y      = dcy_q;
  assign Wp_Count  = cnt_q;
  assign Full      = full_q;
  assign Busy      = busy_q;
`ifdef ONESHOT_PLAY_EN
  assign Play_Done = done_q;
`endif

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Self-checking bench for waypoint_sequencer: directed sequence with randomized duties and
// button choices, checked against a waypoint-list model of record/playback behaviour.
module tb_waypoint_sequencer;

  localparam int AW    = 3;
  localparam int DW    = 6;
  localparam int STEP  = 8;
  localparam int DEPTH = 1 << AW;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic          Reset_Sw, Clear_Sw, Record_Sw, Play_Sw;
  logic [3:0]    bt;
  logic [DW-1:0] Duty_X, Duty_Y, Mem_Rd_X, Mem_Rd_Y;
  logic          Mem_We, Full, Busy;
  logic [AW-1:0] Mem_Waddr, Mem_Raddr;
  logic [DW-1:0] Mem_Wd_X, Mem_Wd_Y, DC_X, DC_Y;
  logic [AW:0]   Wp_Count;
`ifdef ONESHOT_PLAY_EN
  logic          Play_Done;
`endif

  waypoint_sequencer #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STEP_CYCLES(STEP)
  ) dut (
    .sysclk   (sysclk),
    .Reset_Sw (Reset_Sw),
    .Clear_Sw (Clear_Sw),
    .Record_Sw(Record_Sw),
    .Play_Sw  (Play_Sw),
    .Bt_Up    (bt[0]),
    .Bt_Down  (bt[1]),
    .Bt_Left  (bt[2]),
    .Bt_Right (bt[3]),
    .Duty_X   (Duty_X),
    .Duty_Y   (Duty_Y),
    .Mem_Rd_X (Mem_Rd_X),
    .Mem_Rd_Y (Mem_Rd_Y),
    .Mem_We   (Mem_We),
    .Mem_Waddr(Mem_Waddr),
    .Mem_Wd_X (Mem_Wd_X),
    .Mem_Wd_Y (Mem_Wd_Y),
    .Mem_Raddr(Mem_Raddr),
    .DC_X     (DC_X),
    .DC_Y     (DC_Y),
    .Wp_Count (Wp_Count),
    .Full     (Full),
`ifdef ONESHOT_PLAY_EN
    .Play_Done(Play_Done),
`endif
    .Busy     (Busy)
  );

  // Waypoint RAM environment: synchronous write, combinational read
  logic [2*DW-1:0] ram [DEPTH];
  always @(posedge sysclk) if (Mem_We) ram[Mem_Waddr] <= {Mem_Wd_X, Mem_Wd_Y};
  assign Mem_Rd_X = ram[Mem_Raddr][2*DW-1:DW];
  assign Mem_Rd_Y = ram[Mem_Raddr][DW-1:0];

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: the ordered list of recorded waypoints
  logic [DW-1:0] wx[$];
  logic [DW-1:0] wy[$];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected read address k cycles after entering PLAY with n stored waypoints
  function automatic int exp_raddr(input int k, input int n);
    int s;
    s = k / STEP;
    if (n == 0) return 0;
`ifdef ONESHOT_PLAY_EN
    return (s < n - 1) ? s : n - 1;
`else
    return s % n;
`endif
  endfunction

  task automatic do_press(input int hold);
    logic [DW-1:0] dx, dy;
    int n0;
    dx = DW'($urandom);
    dy = DW'($urandom);
    n0 = wx.size();
    bt = 4'b0001 << $urandom_range(3, 0);
    Duty_X = dx;
    Duty_Y = dy;
    tick();
    if (n0 < DEPTH) begin
      check("rec_we", Mem_We, 1);
      check("rec_waddr", Mem_Waddr, n0);
      check("rec_wd_x", Mem_Wd_X, dx);
      check("rec_wd_y", Mem_Wd_Y, dy);
      wx.push_back(dx);
      wy.push_back(dy);
    end else begin
      check("rec_full_no_we", Mem_We, 0);
    end
    check("rec_count", Wp_Count, wx.size());
    check("rec_full", Full, wx.size() == DEPTH);
    check("rec_dc_x", DC_X, dx);
    check("rec_dc_y", DC_Y, dy);
    for (int h = 0; h < hold; h++) begin
      dx = DW'($urandom);
      Duty_X = dx;
      tick();
      check("hold_no_we", Mem_We, 0);
      check("hold_dc_x", DC_X, dx);
    end
    bt = 4'b0000;
    tick();
    check("release_no_we", Mem_We, 0);
  endtask

  task automatic play_run(input int cycles);
    int n, r;
    logic [DW-1:0] lx, ly;
    n = wx.size();
    lx = Duty_X;
    ly = Duty_Y;
    Record_Sw = 1'b0;
    Clear_Sw  = 1'b0;
    Play_Sw   = 1'b1;
    tick();
    for (int k = 0; k < cycles; k++) begin
      r = exp_raddr(k, n);
      check("play_raddr", Mem_Raddr, r);
      if (k > 0) begin
        if (n == 0) begin
          check("play_live_x", DC_X, lx);
          check("play_live_y", DC_Y, ly);
        end else begin
          check("play_dc_x", DC_X, wx[exp_raddr(k - 1, n)]);
          check("play_dc_y", DC_Y, wy[exp_raddr(k - 1, n)]);
        end
      end
`ifdef ONESHOT_PLAY_EN
      check("play_done", Play_Done, (n == 0) || (r == n - 1));
`endif
      lx = DW'($urandom);
      ly = DW'($urandom);
      Duty_X = lx;
      Duty_Y = ly;
      if (k == cycles - 1) Play_Sw = 1'b0;
      tick();
    end
    check("exit_raddr", Mem_Raddr, exp_raddr(cycles, n));
    if (n == 0) check("exit_dc_x", DC_X, lx);
    else        check("exit_dc_x", DC_X, wx[exp_raddr(cycles - 1, n)]);
`ifdef ONESHOT_PLAY_EN
    check("exit_done", Play_Done, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] lv;
    Reset_Sw  = 1'b1;
    Clear_Sw  = 1'b0;
    Record_Sw = 1'b0;
    Play_Sw   = 1'b0;
    bt        = 4'b0000;
    Duty_X    = 6'd17;
    Duty_Y    = 6'd42;
    tick();
    tick();
    check("rst_we", Mem_We, 0);
    check("rst_waddr", Mem_Waddr, 0);
    check("rst_raddr", Mem_Raddr, 0);
    check("rst_dc_x", DC_X, 0);
    check("rst_dc_y", DC_Y, 0);
    check("rst_count", Wp_Count, 0);
    check("rst_full", Full, 0);
    check("rst_busy", Busy, 0);
`ifdef ONESHOT_PLAY_EN
    check("rst_done", Play_Done, 0);
`endif
    Reset_Sw = 1'b0;

    // Full clear from a one-cycle Clear_Sw pulse
    Clear_Sw = 1'b1;
    tick();
    Clear_Sw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("clr_we", Mem_We, 1);
      check("clr_waddr", Mem_Waddr, i);
      check("clr_wd_x", Mem_Wd_X, 0);
      check("clr_wd_y", Mem_Wd_Y, 0);
      check("clr_busy", Busy, 1);
      tick();
    end
    check("clr_end_we", Mem_We, 0);
    check("clr_end_busy", Busy, 0);
    check("clr_end_count", Wp_Count, 0);
    for (int i = 0; i < DEPTH; i++) check("clr_ram", ram[i], 0);

    // Record three waypoints, one with a long hold
    Record_Sw = 1'b1;
    tick();
    tick();
    do_press(0);
    do_press(3);
    do_press(20);
    check("rec3_count", Wp_Count, 3);

    // Playback with three waypoints
    play_run(STEP * 3 * 2 + 5);

    // Fill to capacity and press twice more
    Record_Sw = 1'b1;
    tick();
    tick();
    for (int i = 0; i < DEPTH - 3 + 2; i++) do_press($urandom_range(2, 0));
    check("full_flag", Full, 1);

    // Playback with a full memory
    play_run(STEP * DEPTH + STEP * 2 + 3);

    // Reset in the middle of a clear leaves untouched addresses intact
    Clear_Sw = 1'b1;
    tick();
    Clear_Sw = 1'b0;
    repeat (5) tick();
    check("midclr_waddr", Mem_Waddr, 5);
    check("midclr_we", Mem_We, 1);
    Reset_Sw = 1'b1;
    tick();
    Reset_Sw = 1'b0;
    check("abort_we", Mem_We, 0);
    check("abort_busy", Busy, 0);
    check("abort_count", Wp_Count, 0);
    check("abort_ram6", ram[6], {wx[6], wy[6]});
    check("abort_ram7", ram[7], {wx[7], wy[7]});
    wx.delete();
    wy.delete();
    lv = DW'($urandom);
    Duty_X = lv;
    tick();
    check("idle_live_x", DC_X, lv);
    check("idle_no_we", Mem_We, 0);

    // Playback with no waypoints tracks live duty
    play_run(20);

    // Record and Play both high behaves as RECORD
    Record_Sw = 1'b1;
    Play_Sw   = 1'b1;
    tick();
    tick();
    do_press(1);
    check("prio_count", Wp_Count, 1);
    Record_Sw = 1'b0;
    Play_Sw   = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/waypoint_sequencer.md
Name: waypoint_sequencer

Overview:
Record/playback controller for the dual-port X/Y duty waypoint memory. Captures live pan/tilt duties on button presses in record mode and steps through the stored waypoints at a fixed rate in play mode. Also sequences a full memory clear, and muxes live or played-back duty onto the servo PWM inputs. Sits between the button/duty front end and the waypoint RAM and PWM generators.

Parameters:
ADDR_W, 8, waypoint address width; depth = 2^ADDR_W
DATA_W, 6, duty word width per axis
STEP_CYCLES, 4096, sysclk cycles per playback step (>= 2)

Ports:
sysclk  in  1  system clock, all logic on rising edge
Reset_Sw  in  1  synchronous active-high reset
Clear_Sw  in  1  level; request full memory clear
Record_Sw  in  1  level; record mode
Play_Sw  in  1  level; playback mode
Bt_Up, Bt_Down, Bt_Left, Bt_Right  in  1 each  buttons, already synchronised
Duty_X, Duty_Y  in  DATA_W each  live duty from joystick/button logic
Mem_Rd_X, Mem_Rd_Y  in  DATA_W each  memory read data, combinational from Mem_Raddr
Mem_We  out  1  write strobe
Mem_Waddr  out  ADDR_W  write address
Mem_Wd_X, Mem_Wd_Y  out  DATA_W each  write data
Mem_Raddr  out  ADDR_W  read address
DC_X, DC_Y  out  DATA_W each  duty to PWM generators
Wp_Count  out  ADDR_W+1  number of stored waypoints, 0..2^ADDR_W
Full  out  1  Wp_Count == 2^ADDR_W
Busy  out  1  high during CLEAR

Behaviour:
- All outputs registered. Reset values: Mem_We=0, Mem_Waddr=0, Mem_Wd_*=0, Mem_Raddr=0, DC_*=0, Wp_Count=0, Full=0, Busy=0, state IDLE, step timer 0.
- Reset takes effect on the next edge. Reset asserted mid-CLEAR or mid-PLAY aborts the operation; it does not itself clear memory contents.
- States: IDLE, CLEAR, RECORD, PLAY. Mode priority, evaluated every cycle outside CLEAR: Clear_Sw > Record_Sw > Play_Sw > none.
- Transitions:
  - Clear_Sw high in any non-CLEAR state -> CLEAR.
  - CLEAR is non-interruptible except by reset.
  - Otherwise the state follows the highest-priority asserted switch; IDLE when none is asserted.
- CLEAR:
  - Busy=1. Mem_We=1 for exactly 2^ADDR_W consecutive cycles, Mem_Waddr 0..2^ADDR_W-1, write data 0.
  - Then Wp_Count=0 and the state goes to IDLE with Busy=0. Clear_Sw still high at exit re-enters CLEAR.
- Button edge: any_bt = OR of the four buttons, registered once. press = any_bt & ~any_bt_q.
- RECORD:
  - On a press with Full=0, the next cycle has Mem_We=1, Mem_Waddr=Wp_Count[ADDR_W-1:0] and Mem_Wd_* = Duty_* sampled in the press cycle. Wp_Count increments in that same cycle.
  - Press with Full=1: ignored, no write.
  - Mem_We is a one-cycle pulse. A button held high writes once.
  - DC_* = live Duty_*, one cycle latency.
- PLAY:
  - On entry, Mem_Raddr=0 and the step timer is cleared.
  - The timer counts 0..STEP_CYCLES-1. At terminal count, Mem_Raddr advances by 1; if Mem_Raddr == Wp_Count-1, it wraps to 0.
  - DC_* = Mem_Rd_* registered, one cycle latency from Mem_Raddr.
  - Wp_Count==0: DC_* = live duty and Mem_Raddr holds at 0.
  - Wp_Count==1: Mem_Raddr stays 0.
  - Full (2^ADDR_W entries): wrap at address 2^ADDR_W-1.
- IDLE: DC_* = live duty, Mem_We=0, Mem_Raddr held.
- Leaving PLAY and re-entering restarts from address 0.
- Record_Sw and Play_Sw both high -> RECORD.

Optional Feature:
ONESHOT_PLAY_EN:
- Defined:
  - PLAY stops on the last waypoint (Wp_Count-1) instead of wrapping and holds DC_* at that value.
  - Adds output Play_Done: 1 from the cycle Mem_Raddr reaches the last address until PLAY is exited. Reset value 0.
  - Wp_Count==0: Play_Done=1 immediately.
- Undefined: continuous wrap as above; no Play_Done port.

Test Plan:
- Reset, then CLEAR: Clear_Sw pulse, ADDR_W=8 -> Mem_We high 256 consecutive cycles, addrs 0..255, data 0. Busy high 256 cycles, then Wp_Count=0.
- Record 3 waypoints: Record_Sw=1; press Bt_Up with Duty_X/Y=10/20, Bt_Left at 30/40, Bt_Right held 50 cycles at 5/6 -> writes to addr 0,1,2 with those values, exactly 3 Mem_We pulses, Wp_Count=3.
- Playback wrap, STEP_CYCLES=8: Play_Sw=1 after the above -> Mem_Raddr sequence 0,1,2,0,1 changing every 8 cycles. DC_X follows 10,30,5 with 1-cycle lag.
- Full: ADDR_W=2, 5 presses -> 4 writes (addr 0..3), Full=1, Wp_Count=4, 5th press gives no Mem_We. Playback wraps 3->0.
- Empty play and priority: Wp_Count=0, Play_Sw=1 -> DC_* tracks live duty. Record_Sw+Play_Sw both high -> RECORD behaviour. Reset mid-CLEAR at address 100 -> Mem_We=0 next cycle, state IDLE.
- ONESHOT_PLAY_EN defined, 3 waypoints, STEP_CYCLES=8 -> Mem_Raddr 0,1,2 then holds. Play_Done rises when Mem_Raddr=2, drops on Play_Sw low.
